boton_evento_reg: RTL and testbench
===================================

// Module: boton_evento_reg
// PURPOSE
//  Reader side of the button-filter path: consumes the debounced, synchronized button pulse and
//  the button levels, captures each press as an event in a small FIFO, and exposes it to the
//  RISC-V core as memory-mapped registers with a pop-on-read handshake and a level interrupt.
//  Sits between the button filter and the core's peripheral bus.
// PARAMETERS
//  DEPTH   8   event FIFO entries; power of two, 2..32
//  CNT_W   24  width of the timestamp counter (used only with BOTON_TIMESTAMP_EN)
// PORTS
//  clk_i       in   1   system clock; all logic on its rising edge
//  rst_ni      in   1   asynchronous active-low reset
//  pulso_i     in   1   debounced/synchronized press indication; rising edge = one event
//  botones_i   in   4   synchronized button levels {U,D,L,R}, sampled on the event edge
//  addr_i      in   2   register select: 0=STATUS, 1=DATA, 2=CTRL, 3=reserved
//  rd_en_i     in   1   bus read strobe, 1 cycle
//  wr_en_i     in   1   bus write strobe, 1 cycle
//  wdata_i     in   32  write data (CTRL only)
//  rdata_o     out  32  read data, registered
//  irq_o       out  1   interrupt, level, registered
// BEHAVIOUR
//  - Reset: FIFO empty, count=0, overflow=0, irq_en=0, rdata_o=0, irq_o=0, edge reg=0, timestamp=0.
//  - Event detect: pulso_q <= pulso_i; push request = pulso_i & ~pulso_q. A held pulse yields one event.
//  - Push entry = {ts, 4'b0, botones_i}, botones_i sampled in the same cycle as the edge.
//  - STATUS (addr 0): [0]=empty, [1]=full, [2]=overflow (sticky), [15:8]=count; other bits 0.
//  - DATA (addr 1): rd returns head entry; pops it if non-empty. Read while empty returns 0, no pop.
//  - CTRL (addr 2): rd returns {31'b0, irq_en}. Write: bit0 -> irq_en; bit1=1 flushes FIFO
//    (count=0, pointers 0); bit2=1 clears overflow. Bits 1/2 are self-clearing and not stored.
//  - Addr 3: reads 0, writes ignored. Reads have no side effect except DATA pop.
//  - Latency: rdata_o is valid in the cycle after rd_en_i and holds until the next read.
//  - Push-to-visible: an edge in cycle N updates count/empty in cycle N+1; irq_o rises in N+2.
//  - irq_o <= irq_en & ~empty (uses the registered state). It drops 1 cycle after the pop that empties the FIFO.
//  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
//  - Simultaneous events:
//    . push+pop, not empty: both happen, count unchanged (this includes the full case).
//    . push+pop on empty: read returns 0, push stored, count=1.
//    . push while full, no pop: event dropped, overflow=1, FIFO unchanged.
//    . flush+push same cycle: flush wins, the event is dropped, count=0.
//    . clear-overflow and new overflow same cycle: overflow=1.
//  - rd_en_i & wr_en_i together: write takes effect, read data reflects pre-write state.
//  - Reset asserted mid-operation clears everything asynchronously; the first edge after release needs pulso_i low→high.
// CONFIGURATION
//  BOTON_TIMESTAMP_EN defined: free-running CNT_W-bit cycle counter (wraps), captured into
//    entry bits [8+CNT_W-1:8] at push; DATA[31:8] carries it (zero-extended if CNT_W<24).
//  Undefined: no counter, DATA[31:8]=0, entry storage is 4 bits wide.
// TESTING
//  - Reset: rst_ni=0 mid-traffic -> rdata_o=0, irq_o=0; STATUS read = 0x0000_0001.
//  - Single press: pulso_i high 5 cycles, botones_i=4'b1000 -> count=1; DATA read=0x08, then STATUS=0x01.
//  - Fill/overflow: DEPTH+1 edges -> STATUS=0x0806 (count 8, full, overflow); CTRL write 0x4 -> bit2 clear.
//  - IRQ: CTRL=0x1, one press -> irq_o=1 two cycles after edge; DATA pop -> irq_o=0 next cycle.
//  - Concurrency: full FIFO, push+DATA read in same cycle -> count stays 8, overflow stays 0, order preserved.
//  - Timestamp (macro on): presses 100 cycles apart -> DATA[31:8] difference = 100; flush via CTRL=0x2 -> empty.

Source files
------------

// File: rtl/boton_evento_reg.sv
`default_nettype none
// ============================================================================
//  Module   : boton_evento_reg
//  Brief    : Button event FIFO with memory-mapped STATUS/DATA/CTRL registers,
//             pop-on-read DATA access and a level interrupt for the core.
//  Options  : BOTON_TIMESTAMP_EN - adds a free-running cycle counter whose
//             value is captured with every event (DATA[31:8]).
//  Revision : 1.0 - initial release
// ============================================================================
module boton_evento_reg #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 24
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pulso_i,
  input  logic [3:0]  botones_i,
  input  logic [1:0]  addr_i,
  input  logic        rd_en_i,
  input  logic        wr_en_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int c_ptrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_countW = c_ptrW + 1;
`ifdef BOTON_TIMESTAMP_EN
  localparam int c_entryW = 8 + CNT_W;
`else
  localparam int c_entryW = 4;
`endif

  localparam logic [1:0] c_addrStatus = 2'd0;
  localparam logic [1:0] c_addrData   = 2'd1;
  localparam logic [1:0] c_addrCtrl   = 2'd2;

  logic                r_pulsoQ;
  logic [c_entryW-1:0] r_mem [DEPTH];
  logic [c_ptrW-1:0]   r_wrPtr;
  logic [c_ptrW-1:0]   r_rdPtr;
  logic [c_countW-1:0] r_count;
  logic                r_overflow;
  logic                r_irqEn;
  logic [31:0]         r_rdata;
  logic                r_irq;

  logic                w_empty;
  logic                w_full;
  logic                w_pushReq;
  logic                w_ctrlWr;
  logic                w_flush;
  logic                w_clrOvf;
  logic                w_pop;
  logic                w_push;
  logic                w_setOvf;
  logic [c_entryW-1:0] w_entry;
  logic [31:0]         w_rdMux;
  logic                w_unusedBits;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_countW'(DEPTH));
  assign w_pushReq = pulso_i & ~r_pulsoQ;
  assign w_ctrlWr  = wr_en_i & (addr_i == c_addrCtrl);
  assign w_flush   = w_ctrlWr & wdata_i[1];
  assign w_clrOvf  = w_ctrlWr & wdata_i[2];
  assign w_pop     = rd_en_i & (addr_i == c_addrData) & ~w_empty;
  // A full FIFO still accepts the event when the same cycle frees a slot.
  assign w_push    = w_pushReq & ~w_flush & (~w_full | w_pop);
  assign w_setOvf  = w_pushReq & ~w_flush & w_full & ~w_pop;

  // Upper write-data bits and CNT_W (in the plain build) have no function.
  assign w_unusedBits = ^{wdata_i[31:3], 1'(CNT_W)};

`ifdef BOTON_TIMESTAMP_EN
  logic [CNT_W-1:0] r_ts;

  // Free-running cycle counter that timestamps each event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + 1'b1;
  end

  assign w_entry = {r_ts, 4'b0000, botones_i};
`else
  assign w_entry = botones_i;
`endif

  // Edge-detect register: a held pulse only produces one event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_pulsoQ <= 1'b0;
    else         r_pulsoQ <= pulso_i;
  end

  // Event storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wrPtr] <= w_entry;
  end

  // FIFO pointers and occupancy; flush overrides any push/pop that cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_overflow <= 1'b0;
    else if (w_setOvf) r_overflow <= 1'b1;
    else if (w_clrOvf) r_overflow <= 1'b0;
  end

  // Interrupt enable, the only stored CTRL bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_irqEn <= 1'b0;
    else if (w_ctrlWr) r_irqEn <= wdata_i[0];
  end

  // Read mux built from pre-write state.
  always_comb begin
    w_rdMux = '0;
    case (addr_i)
      c_addrStatus: w_rdMux = {16'h0000, 8'(r_count), 5'b00000, r_overflow, w_full, w_empty};
      c_addrData:   if (!w_empty) w_rdMux = 32'(r_mem[r_rdPtr]);
      c_addrCtrl:   w_rdMux = {31'b0, r_irqEn};
      default:      w_rdMux = '0;
    endcase
  end

  // Read data register: loads on a read strobe and holds until the next one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_rdata <= '0;
    else if (rd_en_i)  r_rdata <= w_rdMux;
  end

  // Level interrupt derived from registered state, one cycle behind count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_irq <= 1'b0;
    else         r_irq <= r_irqEn & ~w_empty;
  end

  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_boton_evento_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_boton_evento_reg
//  Brief    : Self-checking bench for boton_evento_reg (DEPTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_boton_evento_reg;

  logic        clk;
  logic        rstN;
  logic        pulso;
  logic [3:0]  botones;
  logic [1:0]  addr;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  boton_evento_reg #(.DEPTH(8), .CNT_W(24)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .pulso_i   (pulso),
    .botones_i (botones),
    .addr_i    (addr),
    .rd_en_i   (rdEn),
    .wr_en_i   (wrEn),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pul;
    logic [3:0]  bot;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
    logic [31:0] mask;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: compare any read issued last cycle, then drive new inputs.
  task automatic step(input logic p, input logic [3:0] b, input logic rd, input logic wr,
                      input logic [1:0] a, input logic [31:0] wd, input logic [31:0] exp);
    sb_t e;
    @(negedge clk);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check($sformatf("rdata addr%0d", e.addr), rdata & e.mask, e.exp & e.mask);
    end
    pulso = p; botones = b; rdEn = rd; wrEn = wr; addr = a; wdata = wd;
    if (rd) begin
      e.addr = a;
      e.exp  = exp;
      e.mask = 32'hFFFF_FFFF;
`ifdef BOTON_TIMESTAMP_EN
      if (a == 2'd1) e.mask = 32'h0000_00FF;
`endif
      sbQ.push_back(e);
    end
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    step(1'b0, 4'h0, 1'b1, 1'b0, a, 32'h0, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1'b0, 4'h0, 1'b0, 1'b1, a, d, 32'h0);
  endtask

  task automatic press(input logic [3:0] b);
    repeat (3) step(1'b1, b, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    step(1'b0, b, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
  endtask

  function automatic void addRd(input logic [1:0] a, input logic [31:0] e);
    vec_t v;
    v = '{pul: 1'b0, bot: 4'h0, rd: 1'b1, wr: 1'b0, addr: a, wd: 32'h0, exp: e};
    tbl.push_back(v);
  endfunction

  function automatic void addWr(input logic [1:0] a, input logic [31:0] d);
    vec_t v;
    v = '{pul: 1'b0, bot: 4'h0, rd: 1'b0, wr: 1'b1, addr: a, wd: d, exp: 32'h0};
    tbl.push_back(v);
  endfunction

  // Pulse held high for 5 cycles, then low for one.
  function automatic void addPress(input logic [3:0] b);
    vec_t v;
    v = '{pul: 1'b1, bot: b, rd: 1'b0, wr: 1'b0, addr: 2'd0, wd: 32'h0, exp: 32'h0};
    for (int i = 0; i < 5; i++) tbl.push_back(v);
    v.pul = 1'b0;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1;
    logic [31:0] t2;
    logic [23:0] delta;

    rstN = 1'b0; pulso = 1'b0; botones = 4'h0; addr = 2'd0;
    rdEn = 1'b0; wrEn = 1'b0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset irq", {31'b0, irq}, 32'h0);
    rstN = 1'b1;

    // ---------------- table-driven part ----------------
    addRd(2'd0, 32'h0000_0001);
    addRd(2'd2, 32'h0);
    addRd(2'd1, 32'h0);
    addRd(2'd3, 32'h0);
    addWr(2'd3, 32'hFFFF_FFFF);
    addRd(2'd3, 32'h0);
    addRd(2'd2, 32'h0);
    addPress(4'b1000);
    addRd(2'd0, 32'h0000_0100);
    addRd(2'd1, 32'h0000_0008);
    addRd(2'd0, 32'h0000_0001);
    for (int i = 1; i <= 9; i++) addPress(4'(i));
    addRd(2'd0, 32'h0000_0806);
    addWr(2'd2, 32'h0000_0004);
    addRd(2'd0, 32'h0000_0802);
    for (int i = 1; i <= 8; i++) addRd(2'd1, 32'(i));
    addRd(2'd0, 32'h0000_0001);

    foreach (tbl[i]) step(tbl[i].pul, tbl[i].bot, tbl[i].rd, tbl[i].wr,
                          tbl[i].addr, tbl[i].wd, tbl[i].exp);
    idle();

    // ---------------- IRQ timing ----------------
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h1);
    step(1'b1, 4'h5, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);   // edge captured at next posedge
    step(1'b1, 4'h5, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    check("irq one cycle after edge", {31'b0, irq}, 32'h0);
    idle();
    check("irq two cycles after edge", {31'b0, irq}, 32'h1);
    rd(2'd1, 32'h5);
    idle();
    check("irq in pop cycle", {31'b0, irq}, 32'h1);
    idle();
    check("irq after pop", {31'b0, irq}, 32'h0);

    // ---------------- full FIFO push + pop ----------------
    wr(2'd2, 32'h0);
    for (int i = 1; i <= 8; i++) press(4'(i));
    step(1'b1, 4'hF, 1'b1, 1'b0, 2'd1, 32'h0, 32'h1);
    idle();
    rd(2'd0, 32'h0000_0802);
    for (int i = 2; i <= 8; i++) rd(2'd1, 32'(i));
    rd(2'd1, 32'hF);
    rd(2'd0, 32'h0000_0001);

    // ---------------- push + pop on empty ----------------
    step(1'b1, 4'h6, 1'b1, 1'b0, 2'd1, 32'h0, 32'h0);
    idle();
    rd(2'd0, 32'h0000_0100);
    rd(2'd1, 32'h6);

    // ---------------- flush + push same cycle ----------------
    press(4'h3);
    press(4'h4);
    step(1'b1, 4'h9, 1'b0, 1'b1, 2'd2, 32'h2, 32'h0);
    idle();
    rd(2'd0, 32'h0000_0001);
    rd(2'd1, 32'h0);

    // ---------------- read + write CTRL same cycle ----------------
    wr(2'd2, 32'h1);
    step(1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 32'h0, 32'h1);
    rd(2'd2, 32'h0);

    // ---------------- clear-overflow vs new overflow ----------------
    for (int i = 1; i <= 8; i++) press(4'(i));
    step(1'b1, 4'h1, 1'b0, 1'b1, 2'd2, 32'h4, 32'h0);
    idle();
    rd(2'd0, 32'h0000_0806);
    wr(2'd2, 32'h2);
    rd(2'd0, 32'h0000_0005);
    wr(2'd2, 32'h4);
    rd(2'd0, 32'h0000_0001);

`ifdef BOTON_TIMESTAMP_EN
    // ---------------- timestamp spacing ----------------
    step(1'b1, 4'h1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    repeat (99) idle();
    step(1'b1, 4'h2, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    idle();
    rd(2'd1, 32'h1);
    idle();
    t1 = rdata;
    rd(2'd1, 32'h2);
    idle();
    t2 = rdata;
    delta = t2[31:8] - t1[31:8];
    check("timestamp delta", 32'(delta), 32'd100);
    press(4'h7);
    wr(2'd2, 32'h2);
    rd(2'd0, 32'h0000_0001);
`endif

    // ---------------- asynchronous reset mid-traffic ----------------
    wr(2'd2, 32'h1);
    press(4'hC);
    press(4'hD);
    rd(2'd1, 32'hC);
    idle();
    check("irq before reset", {31'b0, irq}, 32'h1);
    #2 rstN = 1'b0;
    #1;
    check("async reset rdata", rdata, 32'h0);
    check("async reset irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    rd(2'd0, 32'h0000_0001);
    rd(2'd2, 32'h0);
    idle();
    idle();

    check("scoreboard drained", 32'(sbQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
